if_id_pipe_stage: RTL and testbench
===================================

// Module: if_id_pipe_stage
// PURPOSE
//  Parametrised IF/ID pipeline stage with a 2-entry skid buffer. Sits between
//  fetch and decode and carries instruction word + PC. Supports valid/ready
//  handshake both sides, stall (if_id_write=0), flush to NOP, and a saturating
//  back-pressure counter. Replaces the fixed 32/11-bit unconditional IF/ID latch.
// PARAMETERS
//  INST_W    32            instruction word width
//  PC_W      11            program counter width
//  NOP_INST  {INST_W{1'b0}} word driven on out_inst whenever out_valid=0
//  CNT_W     16            width of stall_count (saturating)
// PORTS
//  clock        in   1       rising-edge clock, all state
//  reset_n      in   1       asynchronous, active-low reset
//  in_valid     in   1       fetch presents instruccion/pc
//  in_ready     out  1       stage accepts this cycle (combinational)
//  instruccion  in   INST_W  fetched instruction
//  pc           in   PC_W    PC of fetched instruction
//  if_id_write  in   1       0 = hazard stall: freeze stage, no accept, no pop
//  flush        in   1       1 = discard all held entries (branch taken)
//  out_valid    out  1       decode side holds a valid entry (registered)
//  out_ready    in   1       decode consumes entry this cycle
//  salida_inst  out  INST_W  instruction to decode (registered)
//  salida_pc    out  PC_W    PC to decode (registered)
//  occupancy    out  2       entries held: 0,1,2 (registered)
//  stall_count  out  CNT_W   cycles with in_valid=1 && in_ready=0, saturating
// BEHAVIOUR
//  - Reset (async, reset_n=0): out_valid=0, salida_inst=NOP_INST, salida_pc=0,
//    skid entry invalid, occupancy=0, stall_count=0. Applies mid-transfer; all
//    held entries lost.
//  - Storage: main reg (drives outputs) + skid reg. FIFO order always kept.
//  - in_ready = if_id_write & ~flush & (occupancy!=2).
//  - accept = in_valid & in_ready; pop = out_valid & out_ready & if_id_write.
//  - States (occupancy): EMPTY(0), ONE(1), FULL(2). Priority: flush > stall > data.
//    EMPTY: accept -> ONE, main<=input. else EMPTY.
//    ONE:   accept&pop -> ONE, main<=input; accept&~pop -> FULL, skid<=input;
//           ~accept&pop -> EMPTY, salida_inst<=NOP_INST; else ONE, hold.
//    FULL:  no accept. pop -> ONE, main<=skid. else FULL, hold.
//  - Latency: accepted entry appears on salida_* one cycle after accept when
//    stage EMPTY or popping in ONE; throughput 1/cycle with out_ready=1.
//  - flush=1: next cycle EMPTY, out_valid=0, salida_inst=NOP_INST, salida_pc
//    holds last value; concurrent in_valid is not accepted (in_ready=0); a
//    concurrent pop is not reported (flush wins).
//  - if_id_write=0 (flush=0): every register holds; in_ready=0; no pop even if
//    out_ready=1; out_valid/salida_* unchanged.
//  - salida_pc updates only on load into main; never cleared except by reset.
//  - stall_count: +1 per cycle with in_valid & ~in_ready (incl. stall/flush
//    cycles); saturates at 2^CNT_W-1, no wrap; cleared only by reset.
//  - No X propagation: skid contents ignored while skid invalid.
// TESTING
//  1 Reset then stream A0..A3 (pc 0..3), out_ready=1 -> salida_inst A0..A3 on
//    consecutive cycles, 1-cycle latency, occupancy stays 1, stall_count=0.
//  2 out_ready=0, push B0,B1,B2 -> B0 in main, B1 in skid, occupancy=2,
//    in_ready=0, B2 held upstream; out_ready=1 -> B0,B1,B2 in order.
//  3 FULL + if_id_write=0 for 3 cycles with out_ready=1 -> outputs frozen,
//    no pop, stall_count +3 (in_valid=1); release -> order intact.
//  4 FULL + flush=1 with in_valid=1, out_ready=1 -> next cycle occupancy=0,
//    out_valid=0, salida_inst=NOP_INST, input not consumed.
//  5 CNT_W=2, hold in_valid=1 in FULL for 6 cycles -> stall_count 1,2,3,3,3,3.
//  6 Assert reset_n=0 mid-clock while FULL -> outputs reset immediately,
//    without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: carries instruction + PC from fetch to decode through a
// 2-entry skid buffer with valid/ready handshakes, stall, flush and a stall counter.
module if_id_pipe_stage #(
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       PC_W     = 11,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] instruccion,
    input  logic [PC_W-1:0]   pc,
    input  logic              if_id_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] salida_inst,
    output logic [PC_W-1:0]   salida_pc,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           in_entry;
    logic             accept;
    logic             pop;

    assign in_entry = {instruccion, pc};
    assign in_ready = if_id_write & ~flush & (state_q != FULL);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready & if_id_write;

    // State register and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= {NOP_INST, {PC_W{1'b0}}};
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and datapath: flush beats stall, stall beats data movement.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (in_valid && !in_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
            main_d.inst = NOP_INST;
        end else if (if_id_write) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_d      = in_entry;
                        out_valid_d = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_entry;
                    end else if (pop) begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                        main_d.inst = NOP_INST;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    out_valid_d = 1'b0;
                    main_d.inst = NOP_INST;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign salida_inst = main_q.inst;
    assign salida_pc   = main_q.pc;
    assign occupancy   = state_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Randomized scoreboard bench for if_id_pipe_stage: a queue of held entries is the
// reference; the monitor checks presented outputs and popped entries against it.
module tb_if_id_pipe_stage;

    localparam int unsigned INST_W = 32;
    localparam int unsigned PC_W   = 11;
    localparam int unsigned CNT_W  = 6;
    localparam logic [INST_W-1:0] NOP = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ent_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] instruccion;
    logic [PC_W-1:0]   pc;
    logic              if_id_write;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] salida_inst;
    logic [PC_W-1:0]   salida_pc;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_count;

    ent_t             exp_q[$];
    logic [CNT_W-1:0] m_cnt;
    logic [PC_W-1:0]  m_last_pc;
    logic             mon_en;
    int               checks;
    int               errors;

    if_id_pipe_stage #(
        .INST_W  (INST_W),
        .PC_W    (PC_W),
        .NOP_INST(NOP),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruccion(instruccion),
        .pc         (pc),
        .if_id_write(if_id_write),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .salida_inst(salida_inst),
        .salida_pc  (salida_pc),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One random cycle: drive at negedge, update the reference for the coming edge.
    task automatic step(input int pv, input int pr, input int pw, input int pf);
        logic m_rdy;
        @(negedge clock);
        in_valid    = (int'($urandom_range(0, 99)) < pv);
        out_ready   = (int'($urandom_range(0, 99)) < pr);
        if_id_write = (int'($urandom_range(0, 99)) < pw);
        flush       = (int'($urandom_range(0, 99)) < pf);
        instruccion = $urandom;
        pc          = PC_W'($urandom);
        #1;
        m_rdy = if_id_write && !flush && (exp_q.size() < 2);
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        if (in_valid && !m_rdy && (m_cnt != CNT_MAX)) m_cnt = m_cnt + CNT_W'(1);
        if (flush) exp_q.delete();
        else if (in_valid && m_rdy) exp_q.push_back({instruccion, pc});
    endtask

    // Monitor: check presented state each cycle, then score any pop against the queue.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    chk("out_valid", 64'(out_valid), 64'(1));
                    chk("head_inst", 64'(salida_inst), 64'(exp_q[0].inst));
                    chk("head_pc", 64'(salida_pc), 64'(exp_q[0].pc));
                    m_last_pc = exp_q[0].pc;
                end else begin
                    chk("out_valid", 64'(out_valid), 64'(0));
                    chk("nop_inst", 64'(salida_inst), 64'(NOP));
                    chk("held_pc", 64'(salida_pc), 64'(m_last_pc));
                end
                chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
                chk("stall_count", 64'(stall_count), 64'(m_cnt));
                #2;
                if (out_valid && out_ready && if_id_write && !flush) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_nonempty", 64'(0), 64'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_inst", 64'(salida_inst), 64'(e.inst));
                        chk("pop_pc", 64'(salida_pc), 64'(e.pc));
                    end
                end
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        mon_en      = 1'b0;
        m_cnt       = '0;
        m_last_pc   = '0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        if_id_write = 1'b1;
        flush       = 1'b0;
        instruccion = '0;
        pc          = '0;

        repeat (2) @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_inst", 64'(salida_inst), 64'(NOP));
        chk("rst_pc", 64'(salida_pc), 64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_stall_count", 64'(stall_count), 64'(0));
        reset_n = 1'b1;
        #3 mon_en = 1'b1;

        // Streaming, back-pressure, stall-heavy and nearly-blocked mixes.
        for (int i = 0; i < 250; i++) step(80, 95, 100, 0);
        for (int i = 0; i < 250; i++) step(90, 30, 90, 5);
        for (int i = 0; i < 250; i++) step(70, 60, 70, 4);
        for (int i = 0; i < 250; i++) step(95, 10, 95, 2);

        // Fill to FULL, then pull reset low between clock edges.
        for (int i = 0; i < 3; i++) step(100, 0, 100, 0);
        @(negedge clock);
        #3;
        mon_en = 1'b0;
        chk("pre_reset_occupancy", 64'(occupancy), 64'(2));
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_inst", 64'(salida_inst), 64'(NOP));
        chk("async_pc", 64'(salida_pc), 64'(0));
        chk("async_occupancy", 64'(occupancy), 64'(0));
        chk("async_stall_count", 64'(stall_count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
